array_accu_banked: RTL and testbench
====================================

Name: array_accu_banked

Overview:
- Successor to the single-bank lane-wise line accumulator.
- Adds several independent accumulator banks selected per beat, and a wrap or unsigned-saturate arithmetic mode.
- Adds per-lane sticky overflow flags and a valid/ready output handshake with backpressure.
- Sits between the cache-line read path and the write-back/reduction logic: it sums streamed cache lines per bank and emits one result line per flush.

Parameters:
- CACHE_WIDTH, 512, line width in bits; must be a multiple of DATA_WIDTH.
- DATA_WIDTH, 32, lane width in bits; LANES = CACHE_WIDTH/DATA_WIDTH.
- NUM_BANKS, 4, number of independent accumulators; power of two, ≥1. BANK_W = max(1, clog2(NUM_BANKS)).
- SAT_MODE, 0, selects lane arithmetic:
  - 0: modulo 2^DATA_WIDTH wrap.
  - 1: unsigned saturation to all-ones.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block can accept a beat this cycle.
- in_bank  in  BANK_W  target bank of the beat.
- in_last  in  1  final beat of a bank's sum: accumulate it, emit the result, clear the bank.
- array  in  CACHE_WIDTH  LANES unsigned operands; lane i = bits [i*DATA_WIDTH +: DATA_WIDTH].
- out_valid  out  1  result line held on res.
- out_ready  in  1  consumer accepts the result.
- res  out  CACHE_WIDTH  per-lane sums.
- res_bank  out  BANK_W  bank the result came from.
- res_ovf  out  LANES  per-lane overflow seen during this sum.

Behaviour:
- Reset (rst=1 at a posedge), regardless of other inputs:
  - all bank accumulators and overflow flags go to 0.
  - out_valid=0, res=0, res_bank=0, res_ovf=0.
  - in_ready=1 from the next cycle.
  - Reset mid-sum discards all partial sums and any held result.
- in_ready = !out_valid || out_ready. This is combinational, with a single output register. There is no skid buffer, so all input stalls while a result is held.
- Accept: in_valid && in_ready at a posedge. If in_valid=1 with in_ready=0, nothing changes; the producer must hold the beat.
- Lane sum, per lane i: s = acc[b][i] + array[i], computed DATA_WIDTH+1 bits wide; carry = s[DATA_WIDTH].
  - Wrap mode stores s[DATA_WIDTH-1:0].
  - Saturate mode stores all-ones when carry=1, else s[DATA_WIDTH-1:0].
  - ovf[b][i] |= carry in both modes.
- Accepted beat with in_last=0: acc[in_bank] and ovf[in_bank] update per the lane-sum rule. Other banks are unchanged.
- Accepted beat with in_last=1, next cycle:
  - res = lane sums.
  - res_ovf = ovf[b] | carry.
  - res_bank = in_bank, out_valid=1.
  - acc[in_bank] and ovf[in_bank] are cleared to 0.
- Latency from last beat to out_valid is 1 cycle.
- A flush with no prior beats emits array unchanged, with res_ovf=0.
- Output handshake:
  - out_valid && out_ready at a posedge retires the result.
  - out_valid falls next cycle unless a new in_last beat is accepted in the same cycle; in that case the new result loads and out_valid stays 1.
  - res, res_bank and res_ovf are stable while out_valid && !out_ready.
  - res retains its last value after retire; only out_valid qualifies it.
- Back-to-back: a beat every cycle is sustained when out_ready=1. Consecutive in_last beats to different or same banks each produce one result in order.
- A bank that saturates stays at all-ones until flushed. Later beats keep res lanes at all-ones; the overflow flag stays set.
- Same-bank beats on consecutive cycles use the just-updated accumulator; no stale read hazard is permitted.
- State machine per output slot: EMPTY (out_valid=0), FULL (out_valid=1).
  - EMPTY→FULL on accepted in_last.
  - FULL→EMPTY on out_ready with no accepted in_last.
  - FULL→FULL on out_ready with accepted in_last.

Test Plan:
- Defaults, SAT_MODE=0: bank 1 gets 3 beats of all lanes=5, the last with in_last=1, out_ready=1.
  - Expect one cycle after the last beat: out_valid=1, res lanes=15, res_bank=1, res_ovf=0.
  - A following single in_last beat of 1 gives lanes=1, proving the bank was cleared.
- Interleaving: beats alternate bank0 (lanes=1) and bank3 (lanes=2), 4 each, then flush bank3 then bank0.
  - Expect results in order: bank3 lanes=10, then bank0 lanes=5.
- Wrap vs saturate: lane0 gets 0xFFFF_FFF0, then 0x20 with in_last.
  - SAT_MODE=0: res lane0=0x10, res_ovf[0]=1, other lanes ovf=0.
  - SAT_MODE=1: res lane0=0xFFFF_FFFF, res_ovf[0]=1.
- Backpressure: result held with out_ready=0 for 5 cycles while in_valid=1.
  - Expect in_ready=0 and res/res_bank constant throughout; no accumulator changes.
  - On out_ready=1 with an in_last beat pending, the new result loads the next cycle with out_valid staying 1.
- Reset mid-sum: bank2 holds partial 100 and a result is held. Assert rst for 1 cycle.
  - Expect out_valid=0, res=0, res_ovf=0.
  - A subsequent single in_last beat of 7 to bank2 yields lanes=7.
- Empty flush and stall-input ignore:
  - in_last beat 9 to an untouched bank gives lanes=9, res_ovf=0.
  - in_valid=1 with in_ready=0 changes no state.

Source files
------------

// File: rtl/array_accu_banked.sv
// Banked lane-wise line accumulator: one result line per in_last flush, valid 1 cycle after the flush beat.
// One output register, no skid buffer: in_ready = !out_valid || out_ready, so input stalls while a result is held.
module array_accu_banked #(
   parameter int CACHE_WIDTH = 512,
   parameter int DATA_WIDTH  = 32,
   parameter int NUM_BANKS   = 4,
   parameter int SAT_MODE    = 0,
   localparam int LANES      = CACHE_WIDTH / DATA_WIDTH,
   localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [BANK_W-1:0]      in_bank,
   input  logic                   in_last,
   input  logic [CACHE_WIDTH-1:0] array,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [CACHE_WIDTH-1:0] res,
   output logic [BANK_W-1:0]      res_bank,
   output logic [LANES-1:0]       res_ovf
);

   typedef enum logic {
      S_EMPTY = 1'b0,
      S_FULL  = 1'b1
   } state_t;

   state_t                           state_q;
   logic [LANES-1:0][DATA_WIDTH-1:0] acc_q [NUM_BANKS];
   logic [LANES-1:0]                 ovf_q [NUM_BANKS];
   logic [CACHE_WIDTH-1:0]           res_q;
   logic [BANK_W-1:0]                res_bank_q;
   logic [LANES-1:0]                 res_ovf_q;

   logic                             accept;
   logic                             flush;
   logic [BANK_W-1:0]                bank_sel;
   logic [LANES-1:0][DATA_WIDTH-1:0] sum_d;
   logic [LANES-1:0][DATA_WIDTH-1:0] bank_acc_d;
   logic [LANES-1:0]                 carry_d;
   logic [LANES-1:0]                 res_ovf_d;
   logic [LANES-1:0]                 bank_ovf_d;

   assign in_ready  = (state_q == S_EMPTY) || out_ready;
   assign accept    = in_valid && in_ready;
   assign flush     = accept && in_last;
   // A single bank still has a 1-bit select port; pin it so the array index stays in range.
   assign bank_sel  = (NUM_BANKS == 1) ? '0 : in_bank;

   assign out_valid = (state_q == S_FULL);
   assign res       = res_q;
   assign res_bank  = res_bank_q;
   assign res_ovf   = res_ovf_q;

   // Reads the registered accumulator directly, so back-to-back beats to one bank see the latest sum.
   always_comb begin : lane_sum
      logic [DATA_WIDTH:0] s;
      s       = '0;
      sum_d   = '0;
      carry_d = '0;
      for (int i = 0; i < LANES; i++) begin
         s          = {1'b0, acc_q[bank_sel][i]} + {1'b0, array[i*DATA_WIDTH +: DATA_WIDTH]};
         carry_d[i] = s[DATA_WIDTH];
         sum_d[i]   = (SAT_MODE != 0 && s[DATA_WIDTH]) ? {DATA_WIDTH{1'b1}} : s[DATA_WIDTH-1:0];
      end
      res_ovf_d  = ovf_q[bank_sel] | carry_d;
      bank_acc_d = in_last ? '0 : sum_d;
      bank_ovf_d = in_last ? '0 : res_ovf_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_EMPTY;
         res_q      <= '0;
         res_bank_q <= '0;
         res_ovf_q  <= '0;
         for (int b = 0; b < NUM_BANKS; b++) begin
            acc_q[b] <= '0;
            ovf_q[b] <= '0;
         end
      end else begin
         if (accept) begin
            acc_q[bank_sel] <= bank_acc_d;
            ovf_q[bank_sel] <= bank_ovf_d;
         end
         case (state_q)
            S_EMPTY: if (flush) state_q <= S_FULL;
            S_FULL:  if (out_ready && !flush) state_q <= S_EMPTY;
            default: state_q <= S_EMPTY;
         endcase
         if (flush) begin
            res_q      <= sum_d;
            res_bank_q <= bank_sel;
            res_ovf_q  <= res_ovf_d;
         end
      end
   end

endmodule

// File: tb/tb_array_accu_banked.sv
// Bench for array_accu_banked: wrap and saturate instances share stimulus; directed table,
// hand sequences for stall/reset, then random traffic against an arithmetic reference model.
module tb_array_accu_banked;
   localparam int CW = 512;
   localparam int DW = 32;
   localparam int NB = 4;
   localparam int LN = CW / DW;
   localparam int BW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic [BW-1:0] in_bank;
   logic          in_last;
   logic [CW-1:0] array;
   logic          out_ready;

   logic          in_ready_w, in_ready_s, out_valid_w, out_valid_s;
   logic [CW-1:0] res_w, res_s;
   logic [BW-1:0] res_bank_w, res_bank_s;
   logic [LN-1:0] res_ovf_w, res_ovf_s;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   array_accu_banked #(.CACHE_WIDTH(CW), .DATA_WIDTH(DW), .NUM_BANKS(NB), .SAT_MODE(0)) dut_w (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .in_bank(in_bank),
      .in_last(in_last), .array(array), .out_valid(out_valid_w), .out_ready(out_ready),
      .res(res_w), .res_bank(res_bank_w), .res_ovf(res_ovf_w));

   array_accu_banked #(.CACHE_WIDTH(CW), .DATA_WIDTH(DW), .NUM_BANKS(NB), .SAT_MODE(1)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s), .in_bank(in_bank),
      .in_last(in_last), .array(array), .out_valid(out_valid_s), .out_ready(out_ready),
      .res(res_s), .res_bank(res_bank_s), .res_ovf(res_ovf_s));

   typedef struct {
      bit          v;
      bit [BW-1:0] b;
      bit          l;
      bit [31:0]   l0;
      bit [31:0]   ln;
      bit          ordy;
      bit          e_rdy;
      bit          e_ov;
      bit [BW-1:0] e_bank;
      bit [31:0]   e_l0w;
      bit [31:0]   e_l0s;
      bit [31:0]   e_ln;
      bit          e_ovf0;
   } vec_t;

   vec_t tbl[$];

   // reference model state, index [mode] with mode 0 = wrap, 1 = saturate
   bit [31:0]   m_acc [2][NB][LN];
   bit          m_ovf [2][NB][LN];
   bit [31:0]   m_res [2][LN];
   bit          m_rovf[2][LN];
   bit          m_ov;
   bit [BW-1:0] m_rbank;

   bit              r_v, r_l, r_o, r_acc, r_c, r_rdy;
   bit [BW-1:0]     r_b;
   logic [CW-1:0]   r_a, e_res;
   logic [LN-1:0]   e_ovf;
   bit [31:0]       r_x, r_w;
   longint unsigned r_s;

   function automatic vec_t mk(input bit v, input bit [BW-1:0] b, input bit l, input bit [31:0] l0,
                               input bit [31:0] ln, input bit ordy, input bit e_rdy, input bit e_ov,
                               input bit [BW-1:0] e_bank, input bit [31:0] e_l0w, input bit [31:0] e_l0s,
                               input bit [31:0] e_ln, input bit e_ovf0);
      vec_t t;
      t.v = v; t.b = b; t.l = l; t.l0 = l0; t.ln = ln; t.ordy = ordy;
      t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_bank = e_bank;
      t.e_l0w = e_l0w; t.e_l0s = e_l0s; t.e_ln = e_ln; t.e_ovf0 = e_ovf0;
      return t;
   endfunction

   function automatic logic [CW-1:0] line(input bit [31:0] l0, input bit [31:0] ln);
      return {{(LN-1){ln}}, l0};
   endfunction

   task automatic chk(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit v, input bit [BW-1:0] b, input bit l, input bit [31:0] l0,
                        input bit [31:0] ln, input bit ordy);
      in_valid  = v;
      in_bank   = b;
      in_last   = l;
      array     = line(l0, ln);
      out_ready = ordy;
   endtask

   task automatic chk_rdy(input string n, input bit e);
      chk({n, " in_ready_w"}, CW'(in_ready_w), CW'(e));
      chk({n, " in_ready_s"}, CW'(in_ready_s), CW'(e));
   endtask

   // Both instances: used only where no lane overflows, so wrap and saturate agree.
   task automatic chk_out(input string n, input bit ov, input bit [BW-1:0] bk,
                          input logic [CW-1:0] ln, input logic [LN-1:0] ovf);
      chk({n, " out_valid_w"}, CW'(out_valid_w), CW'(ov));
      chk({n, " out_valid_s"}, CW'(out_valid_s), CW'(ov));
      if (ov) begin
         chk({n, " res_w"}, res_w, ln);
         chk({n, " res_s"}, res_s, ln);
         chk({n, " res_bank_w"}, CW'(res_bank_w), CW'(bk));
         chk({n, " res_bank_s"}, CW'(res_bank_s), CW'(bk));
         chk({n, " res_ovf_w"}, CW'(res_ovf_w), CW'(ovf));
         chk({n, " res_ovf_s"}, CW'(res_ovf_s), CW'(ovf));
      end
   endtask

   initial begin
      // v  b  l  lane0        lanes  ordy | rdy ov bank wrap0 sat0 lanes ovf0
      tbl.push_back(mk(1, 1, 0, 5, 5, 1,   1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 0, 5, 5, 1,   1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 1, 1, 5, 5, 1,   1, 1, 1, 15, 15, 15, 0));
      tbl.push_back(mk(1, 1, 1, 1, 1, 1,   1, 1, 1, 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0));
      for (int k = 0; k < 4; k++) begin
         tbl.push_back(mk(1, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0));
         tbl.push_back(mk(1, 3, 0, 2, 2, 1, 1, 0, 0, 0, 0, 0, 0));
      end
      tbl.push_back(mk(1, 3, 1, 2, 2, 1,   1, 1, 3, 10, 10, 10, 0));
      tbl.push_back(mk(1, 0, 1, 1, 1, 1,   1, 1, 0, 5, 5, 5, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 2, 0, 32'hFFFF_FFF0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 2, 1, 32'h20, 0, 1, 1, 1, 2, 32'h10, 32'hFFFF_FFFF, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0, 0));

      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk_rdy("reset", 1'b1);
      chk("reset out_valid_w", CW'(out_valid_w), '0);
      chk("reset out_valid_s", CW'(out_valid_s), '0);
      chk("reset res_w", res_w, '0);
      chk("reset res_bank_w", CW'(res_bank_w), '0);
      chk("reset res_ovf_w", CW'(res_ovf_w), '0);
      chk("reset res_s", res_s, '0);
      @(negedge clk);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].v, tbl[i].b, tbl[i].l, tbl[i].l0, tbl[i].ln, tbl[i].ordy);
         #1;
         chk_rdy($sformatf("tbl%0d", i), tbl[i].e_rdy);
         @(negedge clk);
         chk($sformatf("tbl%0d out_valid_w", i), CW'(out_valid_w), CW'(tbl[i].e_ov));
         chk($sformatf("tbl%0d out_valid_s", i), CW'(out_valid_s), CW'(tbl[i].e_ov));
         if (tbl[i].e_ov) begin
            chk($sformatf("tbl%0d res_w", i), res_w, line(tbl[i].e_l0w, tbl[i].e_ln));
            chk($sformatf("tbl%0d res_s", i), res_s, line(tbl[i].e_l0s, tbl[i].e_ln));
            chk($sformatf("tbl%0d res_bank_w", i), CW'(res_bank_w), CW'(tbl[i].e_bank));
            chk($sformatf("tbl%0d res_bank_s", i), CW'(res_bank_s), CW'(tbl[i].e_bank));
            chk($sformatf("tbl%0d res_ovf_w", i), CW'(res_ovf_w), CW'(tbl[i].e_ovf0));
            chk($sformatf("tbl%0d res_ovf_s", i), CW'(res_ovf_s), CW'(tbl[i].e_ovf0));
         end
      end

      // backpressure: result held 5 cycles with a flush beat pending
      drive(1, 0, 0, 3, 3, 1);
      @(negedge clk);
      chk_out("bp0", 0, 0, '0, '0);
      drive(1, 0, 1, 4, 4, 0);
      #1 chk_rdy("bp1", 1'b1);
      @(negedge clk);
      chk_out("bp1", 1, 0, line(7, 7), '0);
      for (int k = 0; k < 5; k++) begin
         drive(1, 0, 1, 100, 100, 0);
         #1 chk_rdy($sformatf("bp_hold%0d", k), 1'b0);
         @(negedge clk);
         chk_out($sformatf("bp_hold%0d", k), 1, 0, line(7, 7), '0);
      end
      drive(1, 0, 1, 100, 100, 1);
      #1 chk_rdy("bp_release", 1'b1);
      @(negedge clk);
      chk_out("bp_release", 1, 0, line(100, 100), '0);
      drive(0, 0, 0, 0, 0, 1);
      @(negedge clk);
      chk_out("bp_retire", 0, 0, '0, '0);
      chk("bp_retain res_w", res_w, line(100, 100));

      // reset mid-sum with a held result
      drive(1, 2, 0, 100, 100, 1);
      @(negedge clk);
      drive(1, 1, 1, 5, 5, 0);
      @(negedge clk);
      chk_out("rs_held", 1, 1, line(5, 5), '0);
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk_rdy("rs_after", 1'b1);
      chk_out("rs_after", 0, 0, '0, '0);
      chk("rs_after res_w", res_w, '0);
      chk("rs_after res_ovf_w", CW'(res_ovf_w), '0);
      chk("rs_after res_bank_w", CW'(res_bank_w), '0);
      drive(1, 2, 1, 7, 7, 1);
      @(negedge clk);
      chk_out("rs_bank2", 1, 2, line(7, 7), '0);
      drive(1, 0, 1, 9, 9, 1);
      @(negedge clk);
      chk_out("empty_flush", 1, 0, line(9, 9), '0);
      drive(0, 0, 0, 0, 0, 1);
      @(negedge clk);

      // random traffic against the reference model
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_ov = 1'b0;
      m_rbank = '0;
      for (int m = 0; m < 2; m++)
         for (int i = 0; i < LN; i++) begin
            m_res[m][i] = '0;
            m_rovf[m][i] = 1'b0;
            for (int b = 0; b < NB; b++) begin
               m_acc[m][b][i] = '0;
               m_ovf[m][b][i] = 1'b0;
            end
         end

      for (int c = 0; c < 3000; c++) begin
         r_v = ($urandom_range(0, 3) != 0);
         r_l = ($urandom_range(0, 4) == 0);
         r_o = ($urandom_range(0, 3) != 0);
         r_b = BW'($urandom_range(0, NB - 1));
         for (int i = 0; i < LN; i++) begin
            case ($urandom_range(0, 2))
               0:       r_a[i*DW +: DW] = 32'($urandom_range(0, 255));
               1:       r_a[i*DW +: DW] = 32'hFFFF_0000 + 32'($urandom_range(0, 65535));
               default: r_a[i*DW +: DW] = $urandom;
            endcase
         end
         in_valid = r_v; in_bank = r_b; in_last = r_l; array = r_a; out_ready = r_o;
         #1;
         r_rdy = !m_ov || r_o;
         chk_rdy($sformatf("rnd%0d", c), r_rdy);
         r_acc = r_v && r_rdy;
         if (r_acc) begin
            for (int m = 0; m < 2; m++)
               for (int i = 0; i < LN; i++) begin
                  r_x = r_a[i*DW +: DW];
                  r_s = longint'(m_acc[m][r_b][i]) + longint'(r_x);
                  r_c = (r_s > 64'hFFFF_FFFF);
                  r_w = (m == 1 && r_c) ? 32'hFFFF_FFFF : 32'(r_s % 64'h1_0000_0000);
                  if (r_l) begin
                     m_res[m][i]  = r_w;
                     m_rovf[m][i] = m_ovf[m][r_b][i] | r_c;
                     m_acc[m][r_b][i] = '0;
                     m_ovf[m][r_b][i] = 1'b0;
                  end else begin
                     m_acc[m][r_b][i] = r_w;
                     m_ovf[m][r_b][i] = m_ovf[m][r_b][i] | r_c;
                  end
               end
         end
         if (r_acc && r_l) begin
            m_ov = 1'b1;
            m_rbank = r_b;
         end else if (r_o) begin
            m_ov = 1'b0;
         end
         @(negedge clk);
         chk($sformatf("rnd%0d out_valid_w", c), CW'(out_valid_w), CW'(m_ov));
         chk($sformatf("rnd%0d out_valid_s", c), CW'(out_valid_s), CW'(m_ov));
         if (m_ov) begin
            for (int i = 0; i < LN; i++) begin
               e_res[i*DW +: DW] = m_res[0][i];
               e_ovf[i] = m_rovf[0][i];
            end
            chk($sformatf("rnd%0d res_w", c), res_w, e_res);
            chk($sformatf("rnd%0d res_ovf_w", c), CW'(res_ovf_w), CW'(e_ovf));
            for (int i = 0; i < LN; i++) begin
               e_res[i*DW +: DW] = m_res[1][i];
               e_ovf[i] = m_rovf[1][i];
            end
            chk($sformatf("rnd%0d res_s", c), res_s, e_res);
            chk($sformatf("rnd%0d res_ovf_s", c), CW'(res_ovf_s), CW'(e_ovf));
            chk($sformatf("rnd%0d res_bank_w", c), CW'(res_bank_w), CW'(m_rbank));
            chk($sformatf("rnd%0d res_bank_s", c), CW'(res_bank_s), CW'(m_rbank));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
